ysyx_22040759_ifu: RTL

- Instruction fetch unit directly upstream of the single-cycle core (ysyx_22040759_npc).
- Takes the PC offered by the core and issues an AXI4-Lite-style read (AR/R channels) to instruction memory.
- Returns the 32-bit instruction with its PC over a valid/ready handshake; the core must not advance until inst_valid & inst_ready.
- Supports flush (drops the in-flight fetch) and reports bus/alignment faults.

---
 rtl/ysyx_22040759_ifu_pkg.sv | 29 ++
 rtl/ysyx_22040759_ifu_perf.sv | 44 ++++
 rtl/ysyx_22040759_ifu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_ifu_pkg
// Brief    : Shared definitions for the instruction fetch unit: FSM state
//            encodings, the NOP instruction and the AXI OKAY response code.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040759_ifu_pkg;

  // Fetch FSM states, 3-bit encoded
  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_AR   = 3'd1,
    IFU_R    = 3'd2,
    IFU_OUT  = 3'd3,
    IFU_DROP = 3'd4
  } ifu_state_e;

  // addi x0, x0, 0 -- driven on faults and out of reset
  localparam logic [31:0] C_NOP_INST  = 32'h0000_0013;
  localparam logic [1:0]  C_RESP_OKAY = 2'b00;

  // Instructions are word aligned; any low address bit set is a fault
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040759_ifu_perf.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_ifu_perf
// Brief    : Fetch performance counters: completed error-free fetches and
//            cycles spent waiting on the memory bus. Both wrap at 2^32.
//            Only instantiated when YSYX_22040759_IFU_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040759_ifu_perf (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active low
  input  logic        fetch_done,   // error-free instruction handed to the core
  input  logic        bus_stall,    // FSM waiting in AR or R
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Next-count logic; plain increment wraps naturally
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_done) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (bus_stall)  stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22040759_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_ifu
// Brief    : Instruction fetch unit. Accepts a PC from the core, performs one
//            AXI4-Lite style read (AR then R) and hands the instruction back
//            over a valid/ready handshake. Supports flush and reports bus and
//            alignment faults (instruction replaced by NOP).
//            Optional: define YSYX_22040759_IFU_PERF_EN to add the
//            perf_fetch_cnt / perf_stall_cnt counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040759_ifu
  import ysyx_22040759_ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,   // only 32 is supported
  parameter logic [DATA_W-1:0] NOP_INST = C_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active low
  // core PC side
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  // memory read channels
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  // instruction to core
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              fetch_err
`ifdef YSYX_22040759_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              fetch_err_q, fetch_err_d;
  // Remembers a flush seen while the address was still pending, so the
  // eventual read data is discarded instead of delivered.
  logic              drop_q, drop_d;

  // Next-state and datapath update; every field defaults to holding
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    inst_pc_d   = inst_pc_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    drop_d      = drop_q;

    unique case (state_q)
      IFU_IDLE: begin
        drop_d = 1'b0;
        if (pc_valid && !flush) begin
          araddr_d  = pc_in;
          inst_pc_d = pc_in;
          if (is_misaligned(pc_in[1:0])) begin
            // Fault straight to the output stage, no bus access
            inst_d      = NOP_INST;
            fetch_err_d = 1'b1;
            state_d     = IFU_OUT;
          end else begin
            fetch_err_d = 1'b0;
            state_d     = IFU_AR;
          end
        end
      end

      IFU_AR: begin
        // arvalid may not be withdrawn, so a flush here only marks the read
        drop_d = drop_q | flush;
        if (mem_arready) begin
          drop_d  = 1'b0;
          state_d = (drop_q || flush) ? IFU_DROP : IFU_R;
        end
      end

      IFU_R: begin
        if (flush) begin
          // Data arriving with the flush is consumed and thrown away
          state_d = mem_rvalid ? IFU_IDLE : IFU_DROP;
        end else if (mem_rvalid) begin
          if (mem_rresp == C_RESP_OKAY) begin
            inst_d      = mem_rdata;
            fetch_err_d = 1'b0;
          end else begin
            inst_d      = NOP_INST;
            fetch_err_d = 1'b1;
          end
          state_d = IFU_OUT;
        end
      end

      IFU_DROP: begin
        if (mem_rvalid) state_d = IFU_IDLE;
      end

      IFU_OUT: begin
        // A flush voids the transfer even when inst_ready is high
        if (flush || inst_ready) state_d = IFU_IDLE;
      end

      default: state_d = IFU_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IFU_IDLE;
      araddr_q    <= '0;
      inst_pc_q   <= '0;
      inst_q      <= NOP_INST;
      fetch_err_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      inst_pc_q   <= inst_pc_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
      drop_q      <= drop_d;
    end
  end

  // Handshake outputs decoded from state only (pc_ready also gated by flush)
  assign pc_ready    = (state_q == IFU_IDLE) && !flush;
  assign mem_arvalid = (state_q == IFU_AR);
  assign mem_rready  = (state_q == IFU_R) || (state_q == IFU_DROP);
  assign inst_valid  = (state_q == IFU_OUT);
  assign mem_araddr  = araddr_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_err   = fetch_err_q;

`ifdef YSYX_22040759_IFU_PERF_EN
  logic perf_fetch_done;
  logic perf_bus_stall;

  assign perf_fetch_done = (state_q == IFU_OUT) && inst_ready && !flush && !fetch_err_q;
  assign perf_bus_stall  = (state_q == IFU_AR) || (state_q == IFU_R);

  ysyx_22040759_ifu_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_done     (perf_fetch_done),
    .bus_stall      (perf_bus_stall),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule
`default_nettype wire
